load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit in the memory stage, directly downstream of the execute-stage ALU. Takes the ALU result as the effective address, plus the rs2 store data and funct3. Runs one transaction on a req/ack data-memory bus, with byte-lane enables and store-data replication. Returns sign- or zero-extended load data to writeback and stalls the pipeline for the duration.

## Interface
- DATA_WIDTH, 32, datapath and address width (fixed 32 for byte-lane logic)
- clk_i  in  1  clock, single domain
- rst_i  in  1  synchronous reset, active-high
- En_i  in  1  memory instruction present this cycle
- Write_i  in  1  1 = store, 0 = load
- Funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- Addr_i  in  DATA_WIDTH  effective address (ALU result)
- WriteData_i  in  DATA_WIDTH  store data (rs2)
- Busy_o  out  1  pipeline stall request
- Done_o  out  1  one-cycle completion pulse
- Fault_o  out  1  with Done_o: misaligned or illegal funct3, no bus access made
- ReadData_o  out  DATA_WIDTH  extended load data, valid while Done_o
- MemReq_o  out  1  bus request
- MemWe_o  out  1  bus write
- MemAddr_o  out  DATA_WIDTH  word-aligned address, Addr_i with [1:0] = 00
- MemBe_o  out  4  byte enables
- MemWdata_o  out  DATA_WIDTH  lane-replicated store data
- MemAck_i  in  1  bus completion; load data valid this cycle
- MemRdata_i  in  DATA_WIDTH  word read data

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with En_i, legal access: latch the bus fields and the extraction controls (Addr_i[1:0], Funct3_i); go to REQ.
- IDLE with En_i, illegal access: go to DONE with the fault flag set. No MemReq_o.
  - Misaligned: H/HU with Addr_i[0]=1, or W with Addr_i[1:0]≠00.
  - Illegal funct3: 011, 110, 111; for stores, also 100 and 101.
- REQ: MemReq_o stays high. MemAck_i=1 → latch load data, go to DONE. Otherwise stay in REQ, with no timeout.
- DONE: Done_o=1 for one cycle. En_i is ignored here, because the pipeline is still presenting the same instruction. Always return to IDLE.
- Busy_o is combinational: (IDLE && En_i) || REQ. It is 0 in DONE, so the pipeline advances on the DONE edge.
- Byte enables:
  - B: 0001 << Addr[1:0]
  - H: 0011 << {Addr[1],0}
  - W: 1111
- Store data:
  - SB: {4{WriteData_i[7:0]}}
  - SH: {2{WriteData_i[15:0]}}
  - SW: WriteData_i
- Load data: shift MemRdata_i right by 8×Addr[1:0], then extend.
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
- ReadData_o is 0 for stores and for faults, and holds its last value outside DONE.
- Fault_o is asserted only together with Done_o.

## Timing
- Reset values: state IDLE. Outputs MemReq_o, MemWe_o, MemAddr_o, MemBe_o, MemWdata_o, ReadData_o, Done_o, Fault_o are all 0. Busy_o is forced 0 while rst_i=1.
- All outputs except Busy_o are registered.
- Accept at cycle N:
  - MemReq_o rises at N+1.
  - Ack at cycle M ≥ N+1.
  - MemReq_o falls and Done_o is high at M+1.
  - Minimum latency: 2 cycles, with a zero-wait ack in N+1.
- Fault path: accept at N, Done_o and Fault_o at N+1.
- Bus contract: MemAddr_o, MemWe_o, MemBe_o and MemWdata_o are stable while MemReq_o=1. MemAck_i is ignored unless state=REQ.
- Reset mid-transaction: MemReq_o=0 the cycle after rst_i, with no Done_o. A stale MemAck_i in IDLE has no effect.
- Back-to-back accesses: a new instruction is accepted in the IDLE cycle following DONE. Throughput is at most one access per 3 cycles.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum
  - a function computing byte enables
- One natural sub-module: load_extend. It is combinational, takes the offset, funct3 and raw word, and returns the extended data. It is instantiated once on the MemRdata_i capture path.

## Test plan
- SW Addr=0x1004, WriteData=0xDEADBEEF, ack in N+1 → MemBe_o=1111, MemAddr_o=0x1004, MemWdata_o=0xDEADBEEF; Done_o at N+2; Busy_o high N..N+1.
- SB Addr=0x1003, WriteData=0x000000A5 → MemBe_o=1000, MemWdata_o=0xA5A5A5A5, MemAddr_o=0x1000.
- LB/LBU Addr=0x2002, MemRdata_i=0x12F45678 → ReadData_o=0xFFFFFFF4 for LB and 0x000000F4 for LBU.
- LH Addr=0x2002, MemRdata_i=0x8001ABCD, ack delayed 5 cycles → MemReq_o held 6 cycles with fields stable; ReadData_o=0xFFFF8001; Done_o single pulse.
- LW Addr=0x3001, or funct3=011 → Done_o and Fault_o at N+1; MemReq_o never asserts; ReadData_o=0.
- rst_i asserted in REQ, then MemAck_i pulsed the next cycle → MemReq_o=0; no Done_o; FSM in IDLE; next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the byte-lane helpers used on the request path.
package lsu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte enables for the access size in funct3[1:0] at the given offset.
    function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                                input logic [1:0] offset);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = 4'b0011 << {offset[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Illegal funct3 or a misaligned halfword/word access.
    function automatic logic access_fault(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic fault;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = offset[0];
            F3_W:    fault = (offset != 2'b00);
            F3_BU:   fault = write;
            F3_HU:   fault = write | offset[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

    // Replicate store data across every lane so any byte enable finds it.
    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0]      funct3,
                                                    input logic [XLEN-1:0] wdata);
        logic [XLEN-1:0] lanes;
        case (funct3[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/ack bus between the load/store unit and memory.
interface lsu_if;
    import lsu_pkg::*;

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/load_extend.sv
// Aligns the addressed byte/halfword of a read word to bit 0 and extends it.
module load_extend
    import lsu_pkg::*;
(
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    // Select the extension rule for the load type.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch cannot be inferred.
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'd0, shifted[7:0]};
            F3_HU:   data = {16'd0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one req/ack bus transaction per instruction,
// stalling the pipeline until a one-cycle Done_o pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  En_i,
    input  logic                  Write_i,
    input  logic [2:0]            Funct3_i,
    input  logic [DATA_WIDTH-1:0] Addr_i,
    input  logic [DATA_WIDTH-1:0] WriteData_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Fault_o,
    output logic [DATA_WIDTH-1:0] ReadData_o,
    lsu_if.master                 mem
);

    state_t                state, state_n;
    logic                  req_q, req_n;
    logic                  we_q, we_n;
    logic [DATA_WIDTH-1:0] addr_q, addr_n;
    logic [3:0]            be_q, be_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [1:0]            offset_q, offset_n;
    logic [2:0]            funct3_q, funct3_n;
    logic [DATA_WIDTH-1:0] read_data_q, read_data_n;
    logic                  done_q, done_n;
    logic                  fault_q, fault_n;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  bad_access;

    assign bad_access = access_fault(Write_i, Funct3_i, Addr_i[1:0]);

    // Extraction runs on the latched offset/funct3 against the live read word.
    load_extend u_load_extend (
        .offset (offset_q),
        .funct3 (funct3_q),
        .word   (mem.rdata),
        .data   (load_data)
    );

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_n     = state;
        req_n       = req_q;
        we_n        = we_q;
        addr_n      = addr_q;
        be_n        = be_q;
        wdata_n     = wdata_q;
        offset_n    = offset_q;
        funct3_n    = funct3_q;
        read_data_n = read_data_q;
        done_n      = 1'b0;
        fault_n     = 1'b0;

        case (state)
            IDLE: begin
                if (En_i) begin
                    if (bad_access) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        fault_n     = 1'b1;
                        read_data_n = '0;
                    end else begin
                        state_n  = REQ;
                        req_n    = 1'b1;
                        we_n     = Write_i;
                        addr_n   = {Addr_i[DATA_WIDTH-1:2], 2'b00};
                        be_n     = byte_enables(Funct3_i, Addr_i[1:0]);
                        wdata_n  = store_lanes(Funct3_i, WriteData_i);
                        offset_n = Addr_i[1:0];
                        funct3_n = Funct3_i;
                    end
                end
            end
            REQ: begin
                if (mem.ack) begin
                    state_n     = DONE;
                    req_n       = 1'b0;
                    done_n      = 1'b1;
                    read_data_n = we_q ? '0 : load_data;
                end
            end
            // The pipeline still presents this instruction, so En_i is ignored.
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst_i) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            offset_q    <= '0;
            funct3_q    <= '0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_n;
            req_q       <= req_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
            be_q        <= be_n;
            wdata_q     <= wdata_n;
            offset_q    <= offset_n;
            funct3_q    <= funct3_n;
            read_data_q <= read_data_n;
            done_q      <= done_n;
            fault_q     <= fault_n;
        end
    end

    // Stall is combinational so the accepting cycle already holds the pipe.
    assign Busy_o = !rst_i && ((state == IDLE && En_i) || state == REQ);

    assign Done_o     = done_q;
    assign Fault_o    = fault_q;
    assign ReadData_o = read_data_q;
    assign mem.req    = req_q;
    assign mem.we     = we_q;
    assign mem.addr   = addr_q;
    assign mem.be     = be_q;
    assign mem.wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, random accesses
// against a behavioural model, and a reset-during-request sequence.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault;
    logic [31:0] read_data;

    int errors = 0;
    int checks = 0;

    lsu_if mem_bus ();

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .En_i        (en),
        .Write_i     (wr),
        .Funct3_i    (f3),
        .Addr_i      (addr),
        .WriteData_i (wdata),
        .Busy_o      (busy),
        .Done_o      (done),
        .Fault_o     (fault),
        .ReadData_o  (read_data),
        .mem         (mem_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] rdata_exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Expected results from the access rules, using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int size;
        int off;
        logic illegal;
        logic [31:0] x;
        size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(v.addr % 4);
        illegal = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7) ||
                  (v.wr && (v.f3 == 3'd4 || v.f3 == 3'd5));
        r.fault = illegal || ((v.addr % size) != 0);
        r.be    = 4'(((1 << size) - 1) << off);
        r.maddr = v.addr - 32'(off);
        if (size == 1)      r.mwdata = (v.wdata & 32'hFF) * 32'h01010101;
        else if (size == 2) r.mwdata = (v.wdata & 32'hFFFF) * 32'h00010001;
        else                r.mwdata = v.wdata;
        if (v.wr || r.fault) begin
            r.rdata_exp = 32'd0;
        end else begin
            x = v.rdata >> (8 * off);
            if (size == 1) begin
                x = x & 32'hFF;
                if (v.f3 == 3'd0 && x >= 32'h80) x = x + 32'hFFFFFF00;
            end else if (size == 2) begin
                x = x & 32'hFFFF;
                if (v.f3 == 3'd1 && x >= 32'h8000) x = x + 32'hFFFF0000;
            end
            r.rdata_exp = x;
        end
        return r;
    endfunction

    // Drive one instruction through accept, request, completion and idle.
    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk); #1;
        en = 1'b1; wr = v.wr; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        mem_bus.rdata = v.rdata; mem_bus.ack = 1'b0;
        @(negedge clk);
        check({tag, " busy_accept"}, 32'(busy), 32'd1);
        check({tag, " req_accept"}, 32'(mem_bus.req), 32'd0);
        if (!v.fault) begin
            for (int k = 0; k <= v.delay; k++) begin
                @(posedge clk); #1;
                mem_bus.ack = (k == v.delay);
                @(negedge clk);
                check({tag, " req"}, 32'(mem_bus.req), 32'd1);
                check({tag, " busy_req"}, 32'(busy), 32'd1);
                check({tag, " done_req"}, 32'(done), 32'd0);
                check({tag, " addr"}, mem_bus.addr, v.maddr);
                check({tag, " be"}, 32'(mem_bus.be), 32'(v.be));
                check({tag, " we"}, 32'(mem_bus.we), 32'(v.wr));
                if (v.wr) check({tag, " wdata"}, mem_bus.wdata, v.mwdata);
            end
        end
        @(posedge clk); #1;
        mem_bus.ack = 1'b0;
        mem_bus.rdata = $urandom;
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " fault"}, 32'(fault), 32'(v.fault));
        check({tag, " req_done"}, 32'(mem_bus.req), 32'd0);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " read_data"}, read_data, v.rdata_exp);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " fault_after"}, 32'(fault), 32'd0);
        check({tag, " req_idle"}, 32'(mem_bus.req), 32'd0);
        check({tag, " read_hold"}, read_data, v.rdata_exp);
    endtask

    vec_t vecs[10];
    vec_t rv;

    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = '0;

        // Directed table: {wr, f3, addr, wdata, rdata, delay, fault, be, maddr, mwdata, rdata_exp}
        vecs[0] = '{1'b1, F3_W,  32'h1004, 32'hDEADBEEF, 32'h0,        0, 1'b0, 4'b1111, 32'h1004, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, F3_B,  32'h1003, 32'h000000A5, 32'h0,        1, 1'b0, 4'b1000, 32'h1000, 32'hA5A5A5A5, 32'h0};
        vecs[2] = '{1'b0, F3_B,  32'h2002, 32'h0,        32'h12F45678, 0, 1'b0, 4'b0100, 32'h2000, 32'h0,        32'hFFFFFFF4};
        vecs[3] = '{1'b0, F3_BU, 32'h2002, 32'h0,        32'h12F45678, 2, 1'b0, 4'b0100, 32'h2000, 32'h0,        32'h000000F4};
        vecs[4] = '{1'b0, F3_H,  32'h2002, 32'h0,        32'h8001ABCD, 5, 1'b0, 4'b1100, 32'h2000, 32'h0,        32'hFFFF8001};
        vecs[5] = '{1'b0, F3_W,  32'h3001, 32'h0,        32'h11111111, 0, 1'b1, 4'b0000, 32'h0,    32'h0,        32'h0};
        vecs[6] = '{1'b0, 3'b011, 32'h3000, 32'h0,       32'h22222222, 0, 1'b1, 4'b0000, 32'h0,    32'h0,        32'h0};
        vecs[7] = '{1'b1, F3_H,  32'h0002, 32'h1234BEEF, 32'h0,        0, 1'b0, 4'b1100, 32'h0000, 32'hBEEFBEEF, 32'h0};
        vecs[8] = '{1'b0, F3_HU, 32'h0006, 32'h0,        32'h8001ABCD, 1, 1'b0, 4'b1100, 32'h0004, 32'h0,        32'h00008001};
        vecs[9] = '{1'b1, F3_BU, 32'h0004, 32'h12345678, 32'h0,        0, 1'b1, 4'b0000, 32'h0,    32'h0,        32'h0};

        // Reset state, with En_i high to show Busy_o is forced low.
        en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst req", 32'(mem_bus.req), 32'd0);
        check("rst we", 32'(mem_bus.we), 32'd0);
        check("rst addr", mem_bus.addr, 32'd0);
        check("rst be", 32'(mem_bus.be), 32'd0);
        check("rst wdata", mem_bus.wdata, 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        check("rst read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Random accesses against the behavioural model.
        for (int i = 0; i < 40; i++) begin
            rv.wr    = 1'($urandom_range(0, 1));
            rv.f3    = 3'($urandom_range(0, 7));
            rv.addr  = $urandom;
            if ($urandom_range(0, 1) == 0) rv.addr[1:0] = 2'b00;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.delay = int'($urandom_range(0, 3));
            rv = model(rv);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Reset while in REQ, then a stale ack in IDLE.
        @(posedge clk); #1;
        en = 1'b1; wr = 1'b0; f3 = F3_W; addr = 32'h40; wdata = '0;
        @(posedge clk); #1;
        en  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst req_before", 32'(mem_bus.req), 32'd1);
        check("midrst busy_forced", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_bus.ack = 1'b1;
        mem_bus.rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("midrst req", 32'(mem_bus.req), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        mem_bus.ack = 1'b0;
        @(negedge clk);
        check("stale_ack done", 32'(done), 32'd0);
        check("stale_ack req", 32'(mem_bus.req), 32'd0);
        check("stale_ack read_data", read_data, 32'd0);

        rv = '{1'b0, F3_W, 32'h0000_0040, 32'h0, 32'h5A5AA5A5, 1, 1'b0, 4'b1111, 32'h40, 32'h0, 32'h5A5AA5A5};
        run_vec(rv, "post_rst_lw");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
